// File: rtl/regfile_wport_if.sv
// Register-file write-port bundle: writeback and auxiliary requests,
// stall/ready back-pressure, and the registered rf_* write port.
interface regfile_wport_if #(
   parameter int REG_DATA_WIDTH = 32,
   parameter int REG_SEL_BITS   = 5
);
   logic                      wb_valid;
   logic [REG_SEL_BITS-1:0]   wb_sel;
   logic [REG_DATA_WIDTH-1:0] wb_data;
   logic                      wb_stall;
   logic                      aux_valid;
   logic [REG_SEL_BITS-1:0]   aux_sel;
   logic [REG_DATA_WIDTH-1:0] aux_data;
   logic                      aux_ready;
   logic                      rf_wEn;
   logic [REG_SEL_BITS-1:0]   rf_write_sel;
   logic [REG_DATA_WIDTH-1:0] rf_write_data;
   logic                      init_busy;

   modport slave (
      input  wb_valid, wb_sel, wb_data,
      input  aux_valid, aux_sel, aux_data,
      output wb_stall, aux_ready, init_busy,
      output rf_wEn, rf_write_sel, rf_write_data
   );

   modport master (
      output wb_valid, wb_sel, wb_data,
      output aux_valid, aux_sel, aux_data,
      input  wb_stall, aux_ready, init_busy,
      input  rf_wEn, rf_write_sel, rf_write_data
   );
endinterface

// File: rtl/regfile_wport_ctrl.sv
// Register-file write-port controller: zero-fills x1..xN after reset,
// then arbitrates writeback (priority) vs. aux (valid/ready) with anti-starvation.
// Ports: i_clock, i_reset (async, active-low), bus (regfile_wport_if.slave).
module regfile_wport_ctrl #(
   parameter int REG_DATA_WIDTH = 32,
   parameter int REG_SEL_BITS   = 5,
   parameter int STARVE_LIMIT   = 4
) (
   input logic             i_clock,
   input logic             i_reset,
   regfile_wport_if.slave  bus
);
   localparam int SW = REG_SEL_BITS;
   localparam int DW = REG_DATA_WIDTH;
   localparam logic [SW-1:0] LAST  = '1;
   localparam logic [3:0]    LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [SW-1:0]   r_index;
   logic [3:0]      r_starve;
   logic [3:0]      w_starve_nxt;
   logic            r_stall;
   logic            r_wen;
   logic [SW-1:0]   r_sel;
   logic [DW-1:0]   r_data;
   logic            w_wen;
   logic [SW-1:0]   w_sel;
   logic [DW-1:0]   w_data;
   logic            w_ready;
   logic            w_hs;

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) r_state <= S_INIT;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (r_state == S_INIT && r_index == LAST)
         w_state_nxt = S_RUN;
   end

   // Writes to x0 still complete the handshake but never enable the port.
   always_comb begin
      w_ready = 1'b0;
      w_wen   = 1'b0;
      w_sel   = r_sel;
      w_data  = r_data;
      case (r_state)
         S_INIT: begin
            w_wen  = 1'b1;
            w_sel  = r_index;
            w_data = '0;
         end
         S_RUN: begin
            w_ready = !bus.wb_valid;
            if (bus.wb_valid) begin
               w_wen  = |bus.wb_sel;
               w_sel  = bus.wb_sel;
               w_data = bus.wb_data;
            end else if (bus.aux_valid) begin
               w_wen  = |bus.aux_sel;
               w_sel  = bus.aux_sel;
               w_data = bus.aux_data;
            end
         end
         default: ;
      endcase
   end

   assign w_hs = w_ready && bus.aux_valid;

   always_comb begin
      w_starve_nxt = r_starve;
      if (r_state == S_RUN) begin
         if (w_hs)
            w_starve_nxt = '0;
         else if (bus.aux_valid && r_starve != LIMIT)
            w_starve_nxt = r_starve + 4'd1;
      end
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_index  <= SW'(1);
         r_starve <= '0;
         r_stall  <= 1'b0;
         r_wen    <= 1'b0;
         r_sel    <= '0;
         r_data   <= '0;
      end else begin
         if (r_state == S_INIT)
            r_index <= r_index + SW'(1);
         r_starve <= w_starve_nxt;
         // Stall tracks the saturated counter, so it drops on the handshake edge.
         r_stall  <= (w_starve_nxt == LIMIT);
         r_wen    <= w_wen;
         r_sel    <= w_sel;
         r_data   <= w_data;
      end
   end

   assign bus.aux_ready     = w_ready;
   assign bus.wb_stall      = r_stall;
   assign bus.init_busy     = (r_state == S_INIT);
   assign bus.rf_wEn        = r_wen;
   assign bus.rf_write_sel  = r_sel;
   assign bus.rf_write_data = r_data;
endmodule

// File: tb/tb_regfile_wport_ctrl.sv
// Self-checking bench for regfile_wport_ctrl: fill sequence, vector table,
// starvation sequence, randomized traffic vs. a reference model, resets.
module tb_regfile_wport_ctrl;
   localparam int DW = 32;
   localparam int SW = 5;
   localparam int LIM = 4;
   localparam int NREG = 1 << SW;

   typedef struct {
      logic          wv;
      logic [SW-1:0] ws;
      logic [DW-1:0] wd;
      logic          av;
      logic [SW-1:0] as;
      logic [DW-1:0] ad;
      logic          e_rdy;
      logic          e_wen;
      logic [SW-1:0] e_sel;
      logic [DW-1:0] e_data;
      logic          e_stall;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_pass;

   regfile_wport_if #(.REG_DATA_WIDTH(DW), .REG_SEL_BITS(SW)) bus ();

   regfile_wport_ctrl #(
      .REG_DATA_WIDTH(DW),
      .REG_SEL_BITS(SW),
      .STARVE_LIMIT(LIM)
   ) dut (
      .i_clock(clk),
      .i_reset(rst_n),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [DW-1:0] got,
                      input logic [DW-1:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got %h exp %h", nm, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_wen"},   32'(bus.rf_wEn), 32'd0);
      chk({tag, "_sel"},   32'(bus.rf_write_sel), 32'd0);
      chk({tag, "_data"},  bus.rf_write_data, 32'd0);
      chk({tag, "_busy"},  32'(bus.init_busy), 32'd1);
      chk({tag, "_stall"}, 32'(bus.wb_stall), 32'd0);
      chk({tag, "_rdy"},   32'(bus.aux_ready), 32'd0);
   endtask

   task automatic idle_inputs();
      bus.wb_valid  = 1'b0;
      bus.wb_sel    = '0;
      bus.wb_data   = '0;
      bus.aux_valid = 1'b0;
      bus.aux_sel   = '0;
      bus.aux_data  = '0;
   endtask

   // Fill writes x1..x(upto); writeback and aux are driven to prove they are ignored.
   task automatic run_fill(input int upto);
      bus.wb_valid  = 1'b1;
      bus.wb_sel    = 5'd3;
      bus.wb_data   = 32'hCAFEF00D;
      bus.aux_valid = 1'b1;
      bus.aux_sel   = 5'd4;
      bus.aux_data  = 32'h0BADF00D;
      for (int k = 1; k <= upto; k++) begin
         chk("fill_rdy", 32'(bus.aux_ready), 32'd0);
         step();
         chk("fill_wen",  32'(bus.rf_wEn), 32'd1);
         chk("fill_sel",  32'(bus.rf_write_sel), 32'(k));
         chk("fill_data", bus.rf_write_data, 32'd0);
         chk("fill_busy", 32'(bus.init_busy), 32'(k != NREG - 1));
      end
      idle_inputs();
   endtask

   vec_t vecs[8];

   int   m_starve;
   int   m_stall;
   int   aux_wait;
   logic e_rdy;
   logic hs;
   logic e_wen;
   logic [SW-1:0] e_sel;
   logic [DW-1:0] e_data;

   initial begin
      n_chk  = 0;
      n_pass = 0;
      vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,
                  1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0};
      vecs[1] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h12,
                  1'b1, 1'b1, 5'd7, 32'h12, 1'b0};
      vecs[2] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                  1'b1, 1'b0, 5'd0, 32'h0, 1'b0};
      vecs[3] = '{1'b1, 5'd0, 32'h11112222, 1'b0, 5'd0, 32'h0,
                  1'b0, 1'b0, 5'd0, 32'h0, 1'b0};
      vecs[4] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h33334444,
                  1'b1, 1'b0, 5'd0, 32'h0, 1'b0};
      vecs[5] = '{1'b1, 5'd9, 32'h0000AAAA, 1'b1, 5'd10, 32'h0000BBBB,
                  1'b0, 1'b1, 5'd9, 32'h0000AAAA, 1'b0};
      vecs[6] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'h0000BBBB,
                  1'b1, 1'b1, 5'd10, 32'h0000BBBB, 1'b0};
      vecs[7] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,
                  1'b0, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b0};

      rst_n = 1'b0;
      idle_inputs();
      bus.aux_valid = 1'b1;
      step();
      step();
      check_reset("rst");
      rst_n = 1'b1;
      run_fill(NREG - 1);
      step();
      chk("post_fill_wen",   32'(bus.rf_wEn), 32'd0);
      chk("post_fill_stall", 32'(bus.wb_stall), 32'd0);
      chk("post_fill_busy",  32'(bus.init_busy), 32'd0);

      foreach (vecs[i]) begin
         bus.wb_valid  = vecs[i].wv;
         bus.wb_sel    = vecs[i].ws;
         bus.wb_data   = vecs[i].wd;
         bus.aux_valid = vecs[i].av;
         bus.aux_sel   = vecs[i].as;
         bus.aux_data  = vecs[i].ad;
         #1;
         chk("vec_rdy", 32'(bus.aux_ready), 32'(vecs[i].e_rdy));
         step();
         chk("vec_wen", 32'(bus.rf_wEn), 32'(vecs[i].e_wen));
         if (vecs[i].e_wen) begin
            chk("vec_sel",  32'(bus.rf_write_sel), 32'(vecs[i].e_sel));
            chk("vec_data", bus.rf_write_data, vecs[i].e_data);
         end
         chk("vec_stall", 32'(bus.wb_stall), 32'(vecs[i].e_stall));
      end
      idle_inputs();

      // Starvation: writeback hogs the port, stall rises on the LIM-th blocked edge.
      bus.aux_valid = 1'b1;
      bus.aux_sel   = 5'd12;
      bus.aux_data  = 32'h55;
      for (int i = 1; i <= LIM + 1; i++) begin
         bus.wb_valid = 1'b1;
         bus.wb_sel   = SW'(i);
         bus.wb_data  = 32'(100 + i);
         #1;
         chk("stv_rdy", 32'(bus.aux_ready), 32'd0);
         step();
         chk("stv_stall", 32'(bus.wb_stall), 32'(i >= LIM));
         chk("stv_wb_sel", 32'(bus.rf_write_sel), 32'(i));
         chk("stv_wb_data", bus.rf_write_data, 32'(100 + i));
      end
      bus.wb_valid = 1'b0;
      #1;
      chk("stv_hs_rdy", 32'(bus.aux_ready), 32'd1);
      chk("stv_hs_stall", 32'(bus.wb_stall), 32'd1);
      step();
      bus.aux_valid = 1'b0;
      chk("stv_aux_wen",  32'(bus.rf_wEn), 32'd1);
      chk("stv_aux_sel",  32'(bus.rf_write_sel), 32'd12);
      chk("stv_aux_data", bus.rf_write_data, 32'h55);
      chk("stv_stall_fall", 32'(bus.wb_stall), 32'd0);

      // Randomized traffic; the pipeline honours the model's stall.
      m_starve = 0;
      m_stall  = 0;
      aux_wait = 0;
      for (int c = 0; c < 500; c++) begin
         bus.wb_valid = (m_stall == 0) && ($urandom_range(99) < 65);
         bus.wb_sel   = SW'($urandom);
         bus.wb_data  = $urandom;
         if (!bus.aux_valid && $urandom_range(1) == 1) begin
            bus.aux_valid = 1'b1;
            bus.aux_sel   = SW'($urandom);
            bus.aux_data  = $urandom;
            aux_wait      = 0;
         end
         #1;
         e_rdy  = !bus.wb_valid;
         hs     = bus.aux_valid && e_rdy;
         e_wen  = 1'b0;
         e_sel  = '0;
         e_data = '0;
         if (bus.wb_valid) begin
            e_wen  = bus.wb_sel != 0;
            e_sel  = bus.wb_sel;
            e_data = bus.wb_data;
         end else if (hs) begin
            e_wen  = bus.aux_sel != 0;
            e_sel  = bus.aux_sel;
            e_data = bus.aux_data;
         end
         if (hs) m_starve = 0;
         else if (bus.aux_valid && m_starve < LIM) m_starve++;
         m_stall = (m_starve == LIM);
         chk("rnd_rdy", 32'(bus.aux_ready), 32'(e_rdy));
         step();
         chk("rnd_wen", 32'(bus.rf_wEn), 32'(e_wen));
         if (e_wen) begin
            chk("rnd_sel",  32'(bus.rf_write_sel), 32'(e_sel));
            chk("rnd_data", bus.rf_write_data, e_data);
         end
         chk("rnd_stall", 32'(bus.wb_stall), 32'(m_stall));
         if (hs) begin
            bus.aux_valid = 1'b0;
         end else if (bus.aux_valid) begin
            aux_wait++;
            chk("rnd_progress", 32'(aux_wait <= LIM), 32'd1);
         end
      end

      // Reset mid-RUN with a blocked aux request pending.
      bus.wb_valid  = 1'b1;
      bus.wb_sel    = 5'd6;
      bus.aux_valid = 1'b1;
      step();
      rst_n = 1'b0;
      #1;
      check_reset("rst_run");
      idle_inputs();
      step();
      rst_n = 1'b1;
      run_fill(10);
      rst_n = 1'b0;
      #1;
      check_reset("rst_init");
      step();
      rst_n = 1'b1;
      run_fill(NREG - 1);
      step();
      chk("refill_wen", 32'(bus.rf_wEn), 32'd0);
      chk("refill_rdy", 32'(bus.aux_ready), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/regfile_wport_ctrl.md
# regfile_wport_ctrl

- Write-port controller for the integer register file.
- After reset it sequences a zero-fill of every register except x0.
- It then shares the single register-file write port between the pipeline writeback stage (priority, no backpressure) and one auxiliary requester (multi-cycle units, CSR/load return) using a valid/ready handshake.
- A starvation counter requests a pipeline bubble so the auxiliary requester always makes progress.

## Interface
Parameters:
- REG_DATA_WIDTH, 32, data width of the register file
- REG_SEL_BITS, 5, register select width; the file holds 2^REG_SEL_BITS entries
- STARVE_LIMIT, 4, number of blocked auxiliary cycles before wb_stall is raised (1..15)

Ports:
- clock  in  1  single clock; all state on its rising edge
- reset  in  1  asynchronous, active-low reset
- wb_valid  in  1  writeback request this cycle
- wb_sel  in  REG_SEL_BITS  writeback destination register
- wb_data  in  REG_DATA_WIDTH  writeback data
- wb_stall  out  1  registered; asks the pipeline to present no writeback next cycle
- aux_valid  in  1  auxiliary request valid
- aux_sel  in  REG_SEL_BITS  auxiliary destination register
- aux_data  in  REG_DATA_WIDTH  auxiliary data
- aux_ready  out  1  combinational; the transfer occurs when aux_valid && aux_ready
- rf_wEn  out  1  registered write enable to the register file
- rf_write_sel  out  REG_SEL_BITS  registered write select
- rf_write_data  out  REG_DATA_WIDTH  registered write data
- init_busy  out  1  high while the zero-fill runs; the pipeline must hold

## Operation
- Two states: INIT and RUN.
- INIT:
  - Entered on reset assertion.
  - An index counter starts at 1.
  - Each cycle drives rf_wEn=1, rf_write_sel=index, rf_write_data=0, then increments the index.
  - After index 2^REG_SEL_BITS-1 is issued, the next state is RUN.
  - init_busy=1 and aux_ready=0 throughout; wb_valid is ignored.
- RUN:
  - init_busy=0.
  - aux_ready = !wb_valid.
  - Arbitration is fixed priority with writeback first:
    - wb_valid=1: writeback is forwarded to rf_*.
    - Otherwise, on an aux handshake, the aux request is forwarded.
    - Otherwise rf_wEn=0.
  - A request to register 0 is accepted (the aux handshake still completes) but rf_wEn stays 0.
- Starvation counter (width 4):
  - Increments in each RUN cycle with aux_valid && !aux_ready, saturating at STARVE_LIMIT.
  - Clears on an aux handshake.
  - wb_stall is registered high when the counter equals STARVE_LIMIT.
  - wb_stall stays high until the cycle after the aux handshake.
  - The pipeline guarantees wb_valid=0 while it sees wb_stall=1.
  - If wb_valid=1 anyway, writeback still wins. No write is ever dropped.
- No reordering or same-register hazard checking: ordering between the two requesters belongs to the scoreboard.

## Timing
- Reset values: state=INIT, index=1, rf_wEn=0, rf_write_sel=0, rf_write_data=0, init_busy=1, wb_stall=0, counter=0. aux_ready evaluates to 0.
- First zero-fill write appears on the first rising edge after reset deasserts.
- INIT lasts exactly 2^REG_SEL_BITS-1 cycles (31 at default). init_busy falls on the same edge that issues the last fill.
- Request to rf_* latency is one cycle. The pipeline's bypass logic must account for this extra cycle.
- Reset asserted mid-INIT or mid-RUN:
  - All outputs return to reset values immediately.
  - An in-flight aux transfer not yet on rf_* is lost, and the requester re-issues.
  - The fill restarts from index 1.
- Simultaneous wb_valid and aux_valid in RUN: aux_ready=0 that cycle, and aux_data/aux_sel must be held stable until the handshake.
- Counter saturation: the counter never exceeds STARVE_LIMIT and never wraps.

## Test plan
- Reset then release: rf_wEn=1 for 31 consecutive cycles with sel 1..31 and data 0; init_busy falls with the sel=31 write; aux_ready=0 throughout; wb_valid=1 during INIT produces no writeback write.
- RUN, wb_valid=1, wb_sel=5, wb_data=0xDEADBEEF -> next cycle rf_wEn=1, rf_write_sel=5, rf_write_data=0xDEADBEEF.
- RUN, aux_valid=1 (sel=7, data=0x12) with wb idle -> aux_ready=1; next cycle rf_write_sel=7, rf_write_data=0x12.
- RUN, wb_valid held high and aux_valid high, STARVE_LIMIT=4:
  - wb_stall rises on the 4th blocked cycle's edge.
  - The bench drops wb_valid; aux handshake completes, aux write appears one cycle later, and wb_stall falls the cycle after the handshake.
- wb_sel=0 and aux_sel=0 requests -> aux handshake completes, rf_wEn stays 0 for both.
- Assert reset at fill index 10, release -> fill restarts at sel=1 and again runs 31 cycles.
